// File: rtl/axi_tdd_mw_core_if.sv
// rtl/axi_tdd_mw_core_if.sv - register-map config/status and pin bundle for axi_tdd_mw_core
// master = register map side (drives config, reads status); slave = timing core.
interface axi_tdd_mw_core_if #(
   parameter int CHANNEL_COUNT     = 8,
   parameter int WINDOW_COUNT      = 2,
   parameter int REGISTER_WIDTH    = 32,
   parameter int BURST_COUNT_WIDTH = 32
);
   localparam int WIN_TOTAL = CHANNEL_COUNT * WINDOW_COUNT;

   logic                                  tdd_enable;
   logic                                  tdd_sync;
   logic                                  tdd_stop;
   logic [BURST_COUNT_WIDTH-1:0]          burst_count;
   logic [REGISTER_WIDTH-1:0]             startup_delay;
   logic [REGISTER_WIDTH-1:0]             frame_length;
   logic [CHANNEL_COUNT-1:0]              ch_en;
   logic [CHANNEL_COUNT-1:0]              ch_pol;
   logic [WIN_TOTAL-1:0]                  win_en;
   logic [WIN_TOTAL*REGISTER_WIDTH-1:0]   ch_on;
   logic [WIN_TOTAL*REGISTER_WIDTH-1:0]   ch_off;

   logic [1:0]                            tdd_cstate;
   logic                                  tdd_active;
   logic [REGISTER_WIDTH-1:0]             tdd_counter;
   logic [BURST_COUNT_WIDTH-1:0]          tdd_frame_count;
   logic                                  tdd_endof_frame;
   logic [CHANNEL_COUNT-1:0]              tdd_channel;

   modport master (
      output tdd_enable, tdd_sync, tdd_stop, burst_count, startup_delay, frame_length,
             ch_en, ch_pol, win_en, ch_on, ch_off,
      input  tdd_cstate, tdd_active, tdd_counter, tdd_frame_count, tdd_endof_frame,
             tdd_channel
   );

   modport slave (
      input  tdd_enable, tdd_sync, tdd_stop, burst_count, startup_delay, frame_length,
             ch_en, ch_pol, win_en, ch_on, ch_off,
      output tdd_cstate, tdd_active, tdd_counter, tdd_frame_count, tdd_endof_frame,
             tdd_channel
   );
endinterface

// File: rtl/axi_tdd_mw_core.sv
// rtl/axi_tdd_mw_core.sv - TDD frame FSM with multi-window per-channel output generators
// Timing config is shadowed on sync acceptance; ch_en/ch_pol stay live.
module axi_tdd_mw_core #(
   parameter int                       CHANNEL_COUNT     = 8,
   parameter int                       WINDOW_COUNT      = 2,
   parameter int                       REGISTER_WIDTH    = 32,
   parameter int                       BURST_COUNT_WIDTH = 32,
   parameter logic [CHANNEL_COUNT-1:0] DEFAULT_POLARITY  = '0
) (
   input  logic             clk,
   input  logic             resetn,
   axi_tdd_mw_core_if.slave tdd
);
   localparam int WIN_TOTAL = CHANNEL_COUNT * WINDOW_COUNT;
   localparam logic [REGISTER_WIDTH-1:0]    REG_ONE   = {{(REGISTER_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [BURST_COUNT_WIDTH-1:0] BURST_ONE = {{(BURST_COUNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_WAITING = 2'd2,
      ST_RUNNING = 2'd3
   } state_t;

   state_t                              cstate, nstate;
   logic [REGISTER_WIDTH-1:0]           counter, counter_n;
   logic [BURST_COUNT_WIDTH-1:0]        frame_count, frame_count_n;
   logic                                stop_pending, stop_pending_n;
   logic                                load_shadow;
   logic                                active;

   logic [BURST_COUNT_WIDTH-1:0]        sh_burst_count;
   logic [REGISTER_WIDTH-1:0]           sh_startup_delay;
   logic [REGISTER_WIDTH-1:0]           sh_frame_length;
   logic [WIN_TOTAL-1:0]                sh_win_en;
   logic [WIN_TOTAL*REGISTER_WIDTH-1:0] sh_ch_on;
   logic [WIN_TOTAL*REGISTER_WIDTH-1:0] sh_ch_off;

   logic [CHANNEL_COUNT-1:0]            win_state, win_state_n;
   logic [CHANNEL_COUNT-1:0]            set_hit, clr_hit;
   logic [CHANNEL_COUNT-1:0]            channel, channel_n;
   logic [REGISTER_WIDTH-1:0]           frame_last;
   logic                                end_of_frame;

   // A zero frame length behaves as a one-cycle frame.
   assign frame_last   = (sh_frame_length == '0) ? '0 : sh_frame_length - REG_ONE;
   assign end_of_frame = (cstate == ST_RUNNING) && (counter == frame_last);

   always_comb begin
      nstate         = cstate;
      counter_n      = counter;
      frame_count_n  = frame_count;
      stop_pending_n = stop_pending;
      load_shadow    = 1'b0;
      if (!tdd.tdd_enable) begin
         nstate         = ST_IDLE;
         counter_n      = '0;
         frame_count_n  = '0;
         stop_pending_n = 1'b0;
      end else begin
         case (cstate)
            ST_IDLE: begin
               nstate = ST_ARMED;
            end
            ST_ARMED: begin
               if (tdd.tdd_sync) begin
                  load_shadow   = 1'b1;
                  counter_n     = '0;
                  frame_count_n = '0;
                  nstate        = (tdd.startup_delay != '0) ? ST_WAITING : ST_RUNNING;
               end
            end
            ST_WAITING: begin
               if (counter == sh_startup_delay - REG_ONE) begin
                  counter_n = '0;
                  nstate    = ST_RUNNING;
               end else begin
                  counter_n = counter + REG_ONE;
               end
            end
            ST_RUNNING: begin
               if (tdd.tdd_stop) begin
                  stop_pending_n = 1'b1;
               end
               if (end_of_frame) begin
                  counter_n     = '0;
                  frame_count_n = frame_count + BURST_ONE;
                  // Stop wins over burst completion.
                  if (stop_pending || tdd.tdd_stop) begin
                     nstate         = ST_IDLE;
                     stop_pending_n = 1'b0;
                  end else if ((sh_burst_count != '0) &&
                               (frame_count + BURST_ONE == sh_burst_count)) begin
                     nstate         = ST_ARMED;
                     stop_pending_n = 1'b0;
                  end
               end else begin
                  counter_n = counter + REG_ONE;
               end
            end
            default: begin
               nstate = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      set_hit = '0;
      clr_hit = '0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
         for (int w = 0; w < WINDOW_COUNT; w++) begin
            if (sh_win_en[c*WINDOW_COUNT + w]) begin
               if (sh_ch_on[(c*WINDOW_COUNT + w)*REGISTER_WIDTH +: REGISTER_WIDTH] == counter) begin
                  set_hit[c] = 1'b1;
               end
               if (sh_ch_off[(c*WINDOW_COUNT + w)*REGISTER_WIDTH +: REGISTER_WIDTH] == counter) begin
                  clr_hit[c] = 1'b1;
               end
            end
         end
      end
   end

   // Priority per channel: end of frame clears, then set, then clear, else hold.
   always_comb begin
      win_state_n = win_state;
      if (!tdd.tdd_enable) begin
         win_state_n = '0;
      end else if (cstate == ST_RUNNING) begin
         if (end_of_frame) begin
            win_state_n = '0;
         end else begin
            win_state_n = set_hit | (win_state & ~clr_hit);
         end
      end
   end

   assign channel_n = (tdd.ch_en & (win_state_n ^ tdd.ch_pol)) | (~tdd.ch_en & tdd.ch_pol);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cstate           <= ST_IDLE;
         counter          <= '0;
         frame_count      <= '0;
         stop_pending     <= 1'b0;
         active           <= 1'b0;
         sh_burst_count   <= '0;
         sh_startup_delay <= '0;
         sh_frame_length  <= '0;
         sh_win_en        <= '0;
         sh_ch_on         <= '0;
         sh_ch_off        <= '0;
         win_state        <= '0;
         channel          <= DEFAULT_POLARITY;
      end else begin
         cstate       <= nstate;
         counter      <= counter_n;
         frame_count  <= frame_count_n;
         stop_pending <= stop_pending_n;
         active       <= (nstate == ST_WAITING) || (nstate == ST_RUNNING);
         win_state    <= win_state_n;
         channel      <= channel_n;
         if (load_shadow) begin
            sh_burst_count   <= tdd.burst_count;
            sh_startup_delay <= tdd.startup_delay;
            sh_frame_length  <= tdd.frame_length;
            sh_win_en        <= tdd.win_en;
            sh_ch_on         <= tdd.ch_on;
            sh_ch_off        <= tdd.ch_off;
         end
      end
   end

   assign tdd.tdd_cstate      = cstate;
   assign tdd.tdd_active      = active;
   assign tdd.tdd_counter     = counter;
   assign tdd.tdd_frame_count = frame_count;
   assign tdd.tdd_endof_frame = end_of_frame;
   assign tdd.tdd_channel     = channel;
endmodule

// File: tb/tb_axi_tdd_mw_core.sv
// tb/tb_axi_tdd_mw_core.sv - directed self-checking bench for axi_tdd_mw_core
module tb_axi_tdd_mw_core;
   localparam int CH = 8;
   localparam int WC = 2;
   localparam int RW = 32;
   localparam int BW = 32;
   localparam logic [CH-1:0] DEF_POL = 8'h81;

   logic       clk = 1'b0;
   logic       resetn;
   int         n_pass = 0;
   int         n_fail = 0;
   int         n_total = 0;
   logic [7:0] exp_ch;

   axi_tdd_mw_core_if #(
      .CHANNEL_COUNT(CH), .WINDOW_COUNT(WC), .REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW)
   ) bus ();

   axi_tdd_mw_core #(
      .CHANNEL_COUNT(CH), .WINDOW_COUNT(WC), .REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW),
      .DEFAULT_POLARITY(DEF_POL)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .tdd    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_win(input int c, input int w, input logic en,
                          input logic [RW-1:0] on, input logic [RW-1:0] off);
      bus.win_en[c*WC + w]           = en;
      bus.ch_on[(c*WC + w)*RW +: RW]  = on;
      bus.ch_off[(c*WC + w)*RW +: RW] = off;
   endtask

   task automatic sync_pulse();
      bus.tdd_sync = 1'b1;
      tick();
      bus.tdd_sync = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn            = 1'b0;
      bus.tdd_enable    = 1'b0;
      bus.tdd_sync      = 1'b0;
      bus.tdd_stop      = 1'b0;
      bus.burst_count   = '0;
      bus.startup_delay = '0;
      bus.frame_length  = '0;
      bus.ch_en         = '0;
      bus.ch_pol        = '0;
      bus.win_en        = '0;
      bus.ch_on         = '0;
      bus.ch_off        = '0;
      tick(2);
      check("rst_channel", bus.tdd_channel, DEF_POL);
      check("rst_cstate", bus.tdd_cstate, 0);
      check("rst_counter", bus.tdd_counter, 0);
      check("rst_frame_count", bus.tdd_frame_count, 0);
      check("rst_active", bus.tdd_active, 0);
      check("rst_eof", bus.tdd_endof_frame, 0);

      // Basic frame: two 10-cycle frames, ch0 high for counter 3..5
      bus.frame_length  = 10;
      bus.startup_delay = 0;
      bus.burst_count   = 2;
      bus.ch_en         = 8'h03;
      bus.ch_pol        = 8'h00;
      set_win(0, 0, 1'b1, 2, 5);
      resetn         = 1'b1;
      bus.tdd_enable = 1'b1;
      tick();
      check("basic_armed", bus.tdd_cstate, 1);
      check("basic_pol_after_reset", bus.tdd_channel, 8'h00);
      sync_pulse();
      check("basic_running", bus.tdd_cstate, 3);
      check("basic_active", bus.tdd_active, 1);
      for (int f = 0; f < 2; f++) begin
         for (int n = 0; n < 10; n++) begin
            check("basic_counter", bus.tdd_counter, n);
            check("basic_channel", bus.tdd_channel, (n >= 3 && n <= 5) ? 8'h01 : 8'h00);
            check("basic_eof", bus.tdd_endof_frame, (n == 9) ? 1 : 0);
            check("basic_frame_count", bus.tdd_frame_count, f);
            tick();
         end
      end
      check("basic_rearm", bus.tdd_cstate, 1);
      check("basic_final_fc", bus.tdd_frame_count, 2);
      check("basic_inactive", bus.tdd_active, 0);
      check("basic_counter_zero", bus.tdd_counter, 0);

      // Startup delay of 4 before an 8-cycle frame
      bus.startup_delay = 4;
      bus.frame_length  = 8;
      bus.burst_count   = 1;
      sync_pulse();
      check("sd_active", bus.tdd_active, 1);
      for (int n = 0; n < 4; n++) begin
         check("sd_waiting", bus.tdd_cstate, 2);
         check("sd_counter", bus.tdd_counter, n);
         tick();
      end
      check("sd_running", bus.tdd_cstate, 3);
      check("sd_run_counter", bus.tdd_counter, 0);
      tick(7);
      check("sd_eof", bus.tdd_endof_frame, 1);
      check("sd_last_counter", bus.tdd_counter, 7);
      tick();
      check("sd_rearm", bus.tdd_cstate, 1);
      check("sd_frame_count", bus.tdd_frame_count, 1);

      // Multi-window plus on==off window and a disabled inverted channel
      bus.startup_delay = 0;
      bus.frame_length  = 10;
      bus.burst_count   = 1;
      bus.ch_pol        = 8'h04;
      set_win(0, 0, 1'b1, 4, 4);
      set_win(1, 0, 1'b1, 1, 3);
      set_win(1, 1, 1'b1, 5, 7);
      sync_pulse();
      for (int n = 0; n < 10; n++) begin
         exp_ch = 8'h04 | (((n >= 2 && n <= 3) || (n >= 6 && n <= 7)) ? 8'h02 : 8'h00)
                        | ((n >= 5) ? 8'h01 : 8'h00);
         check("mw_channel", bus.tdd_channel, exp_ch);
         tick();
      end
      check("mw_rearm", bus.tdd_cstate, 1);
      check("mw_idle_channel", bus.tdd_channel, 8'h04);

      // Graceful stop in the third frame of an infinite burst
      bus.burst_count  = 0;
      bus.frame_length = 6;
      sync_pulse();
      tick(12);
      check("gs_frame_count", bus.tdd_frame_count, 2);
      check("gs_counter0", bus.tdd_counter, 0);
      tick(2);
      check("gs_counter2", bus.tdd_counter, 2);
      bus.tdd_stop = 1'b1;
      tick();
      bus.tdd_stop = 1'b0;
      check("gs_still_running", bus.tdd_cstate, 3);
      check("gs_counter3", bus.tdd_counter, 3);
      tick(2);
      check("gs_eof", bus.tdd_endof_frame, 1);
      check("gs_counter5", bus.tdd_counter, 5);
      tick();
      check("gs_idle", bus.tdd_cstate, 0);
      check("gs_final_fc", bus.tdd_frame_count, 3);
      check("gs_counter_zero", bus.tdd_counter, 0);
      check("gs_channel_pol", bus.tdd_channel, 8'h04);
      check("gs_inactive", bus.tdd_active, 0);
      tick();
      check("gs_rearm", bus.tdd_cstate, 1);

      // Shadowing; stop in ARMED and sync in RUNNING are ignored
      bus.frame_length = 10;
      bus.burst_count  = 2;
      bus.tdd_stop     = 1'b1;
      tick();
      bus.tdd_stop     = 1'b0;
      check("sh_stop_ignored_armed", bus.tdd_cstate, 1);
      sync_pulse();
      tick(2);
      bus.frame_length = 20;
      sync_pulse();
      check("sh_sync_ignored", bus.tdd_counter, 3);
      tick(6);
      check("sh_old_len_eof", bus.tdd_endof_frame, 1);
      check("sh_old_len_counter", bus.tdd_counter, 9);
      tick();
      check("sh_continue", bus.tdd_cstate, 3);
      check("sh_fc1", bus.tdd_frame_count, 1);
      tick(9);
      check("sh_eof2", bus.tdd_endof_frame, 1);
      tick();
      check("sh_rearm", bus.tdd_cstate, 1);
      check("sh_fc2", bus.tdd_frame_count, 2);
      bus.burst_count = 1;
      sync_pulse();
      check("sh_new_running", bus.tdd_cstate, 3);
      tick(10);
      check("sh_new_counter10", bus.tdd_counter, 10);
      check("sh_new_no_eof", bus.tdd_endof_frame, 0);
      tick(9);
      check("sh_new_eof", bus.tdd_endof_frame, 1);
      check("sh_new_counter19", bus.tdd_counter, 19);
      tick();
      check("sh_new_rearm", bus.tdd_cstate, 1);
      check("sh_new_fc", bus.tdd_frame_count, 1);

      // frame_length 0 acts as one-cycle frames
      bus.frame_length = 0;
      bus.burst_count  = 3;
      sync_pulse();
      check("fl0_running", bus.tdd_cstate, 3);
      check("fl0_eof", bus.tdd_endof_frame, 1);
      tick();
      check("fl0_fc1", bus.tdd_frame_count, 1);
      check("fl0_eof1", bus.tdd_endof_frame, 1);
      tick();
      check("fl0_fc2", bus.tdd_frame_count, 2);
      tick();
      check("fl0_rearm", bus.tdd_cstate, 1);
      check("fl0_fc3", bus.tdd_frame_count, 3);

      // Abort by disable, then asynchronous reset mid-frame
      bus.frame_length = 10;
      bus.burst_count  = 0;
      set_win(0, 0, 1'b1, 1, 8);
      sync_pulse();
      tick(3);
      check("ab_counter3", bus.tdd_counter, 3);
      check("ab_channel_on", bus.tdd_channel, 8'h07);
      bus.tdd_enable = 1'b0;
      tick();
      check("ab_idle", bus.tdd_cstate, 0);
      check("ab_counter", bus.tdd_counter, 0);
      check("ab_fc", bus.tdd_frame_count, 0);
      check("ab_channel_pol", bus.tdd_channel, 8'h04);
      check("ab_inactive", bus.tdd_active, 0);
      tick();
      check("ab_stay_idle", bus.tdd_cstate, 0);
      bus.tdd_enable = 1'b1;
      tick();
      check("ab_rearm", bus.tdd_cstate, 1);
      sync_pulse();
      tick(3);
      check("ar_channel_on", bus.tdd_channel, 8'h07);
      resetn = 1'b0;
      #1;
      check("ar_channel", bus.tdd_channel, DEF_POL);
      check("ar_cstate", bus.tdd_cstate, 0);
      check("ar_counter", bus.tdd_counter, 0);
      check("ar_active", bus.tdd_active, 0);
      tick();
      resetn = 1'b1;
      tick();
      check("ar_rearm", bus.tdd_cstate, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
